nx_mimosa_v40_nis_calc: RTL and testbench

Computes the Normalized Innovation Squared for the CV and CA forward filters and drives the `nis_cv` / `nis_ca` / `nis_valid` interface of the hybrid stream selector. It pairs one update from each filter (innovation y and innovation covariance S, 2-D position measurement) and evaluates NIS = yᵀS⁻¹y in Q15.16 on one shared sequential datapath. It emits both values together as a single one-cycle `nis_valid` pulse.

---
 rtl/nx_mimosa_v40_nis_calc.sv | 210 +++++++++++++++++++++
 tb/tb_nx_mimosa_v40_nis_calc.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nx_mimosa_v40_nis_calc.sv
// NIS = y'*inv(S)*y for paired CV/CA filter updates (2-D, Q15.16).
// One shared mul/sum/restoring-divide datapath evaluates CV then CA.
module nx_mimosa_v40_nis_calc #(
  parameter int unsigned MEAS_DIM     = 2,
  parameter int unsigned PAIR_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [MEAS_DIM-1:0][31:0] cv_y,
  input  logic [31:0]              cv_s11,
  input  logic [31:0]              cv_s12,
  input  logic [31:0]              cv_s22,
  input  logic                     cv_valid,
  input  logic [MEAS_DIM-1:0][31:0] ca_y,
  input  logic [31:0]              ca_s11,
  input  logic [31:0]              ca_s12,
  input  logic [31:0]              ca_s22,
  input  logic                     ca_valid,
  output logic [31:0]              nis_cv,
  output logic [31:0]              nis_ca,
  output logic                     nis_valid,
  output logic [1:0]               degenerate,
  output logic                     busy,
  output logic                     pair_drop,
  output logic                     overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_SUM  = 2'd2;
  localparam logic [1:0] S_DIV  = 2'd3;
  localparam int unsigned CW = $clog2(PAIR_TIMEOUT + 1);
  localparam logic signed [63:0] SMAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] SMIN = -64'sh0000_0000_8000_0000;

  function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
    if (v > SMAX) return 32'sh7FFF_FFFF;
    if (v < SMIN) return 32'sh8000_0000;
    return v[31:0];
  endfunction

  function automatic logic signed [31:0] fp_mul(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return sat32(p >>> 16);
  endfunction

  // Index 0 = CV stream, index 1 = CA stream.
  logic signed [31:0] cap_y1_q [2], cap_y2_q [2], cap_s11_q [2], cap_s12_q [2], cap_s22_q [2];
  logic signed [31:0] cap_y1_d [2], cap_y2_d [2], cap_s11_d [2], cap_s12_d [2], cap_s22_d [2];
  logic signed [31:0] w_y1_q [2], w_y2_q [2], w_s11_q [2], w_s12_q [2], w_s22_q [2];
  logic signed [31:0] w_y1_d [2], w_y2_d [2], w_s11_d [2], w_s12_d [2], w_s22_d [2];
  logic signed [31:0] p_yy11_q, p_yy12_q, p_yy22_q, p_sd_q, p_so_q;
  logic signed [31:0] p_yy11_d, p_yy12_d, p_yy22_d, p_sd_d, p_so_d;
  logic [1:0]    state_q, state_d;
  logic          sel_q, sel_d;
  logic [4:0]    dcnt_q, dcnt_d;
  logic          have_cv_q, have_cv_d, have_ca_q, have_ca_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [31:0]   rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
  logic          force_q, force_d, deg_cur_q, deg_cur_d, deg_cv_q, deg_cv_d;
  logic [31:0]   force_val_q, force_val_d, res_cv_q, res_cv_d;
  logic [31:0]   nis_cv_q, nis_cv_d, nis_ca_q, nis_ca_d;
  logic [1:0]    deg_q, deg_d;
  logic          nis_valid_q, nis_valid_d, pair_drop_q, pair_drop_d, overrun_q, overrun_d;

  logic               take, lone, idle_in, tmo, ge;
  logic signed [31:0] t1, t2, t2x2, t3, num, det;
  logic signed [33:0] acc;
  logic [32:0]        r2;
  logic [31:0]        q_next, final_q;

  assign take    = (state_q == S_IDLE) && have_cv_q && have_ca_q;
  assign lone    = have_cv_q ^ have_ca_q;
  assign idle_in = lone && !cv_valid && !ca_valid;
  assign tmo     = idle_in && (tcnt_q == CW'(PAIR_TIMEOUT - 1));

  // Quadratic form of the 2x2 adjugate; the division by det happens in DIV.
  assign t1   = fp_mul(w_s22_q[sel_q], p_yy11_q);
  assign t2   = fp_mul(w_s12_q[sel_q], p_yy12_q);
  assign t3   = fp_mul(w_s11_q[sel_q], p_yy22_q);
  assign t2x2 = sat32(64'(t2) <<< 1);
  assign acc  = 34'(t1) - 34'(t2x2) + 34'(t3);
  assign num  = sat32(64'(acc));
  assign det  = sat32(64'(p_sd_q) - 64'(p_so_q));

  // Quotient bits shift into quo_q as the dividend bits shift out of its top.
  assign r2      = {rem_q, quo_q[31]};
  assign ge      = r2 >= {1'b0, dsr_q};
  assign q_next  = {quo_q[30:0], ge};
  assign final_q = force_q ? force_val_q : q_next;

  always_comb begin
    cap_y1_d = cap_y1_q;  cap_y2_d = cap_y2_q;
    cap_s11_d = cap_s11_q; cap_s12_d = cap_s12_q; cap_s22_d = cap_s22_q;
    w_y1_d = w_y1_q; w_y2_d = w_y2_q;
    w_s11_d = w_s11_q; w_s12_d = w_s12_q; w_s22_d = w_s22_q;
    p_yy11_d = p_yy11_q; p_yy12_d = p_yy12_q; p_yy22_d = p_yy22_q;
    p_sd_d = p_sd_q; p_so_d = p_so_q;
    state_d = state_q; sel_d = sel_q; dcnt_d = dcnt_q;
    rem_d = rem_q; quo_d = quo_q; dsr_d = dsr_q;
    force_d = force_q; force_val_d = force_val_q; deg_cur_d = deg_cur_q;
    res_cv_d = res_cv_q; deg_cv_d = deg_cv_q;
    nis_cv_d = nis_cv_q; nis_ca_d = nis_ca_q; deg_d = deg_q;
    nis_valid_d = 1'b0;
    pair_drop_d = tmo;
    overrun_d   = !take && ((cv_valid && have_cv_q) || (ca_valid && have_ca_q));
    tcnt_d      = (idle_in && !tmo) ? tcnt_q + 1'b1 : '0;
    have_cv_d   = cv_valid ? 1'b1 : ((take || (tmo && have_cv_q)) ? 1'b0 : have_cv_q);
    have_ca_d   = ca_valid ? 1'b1 : ((take || (tmo && have_ca_q)) ? 1'b0 : have_ca_q);

    if (cv_valid) begin
      cap_y1_d[0] = cv_y[0]; cap_y2_d[0] = cv_y[1];
      cap_s11_d[0] = cv_s11; cap_s12_d[0] = cv_s12; cap_s22_d[0] = cv_s22;
    end
    if (ca_valid) begin
      cap_y1_d[1] = ca_y[0]; cap_y2_d[1] = ca_y[1];
      cap_s11_d[1] = ca_s11; cap_s12_d[1] = ca_s12; cap_s22_d[1] = ca_s22;
    end

    case (state_q)
      S_IDLE: if (take) begin
        w_y1_d = cap_y1_q; w_y2_d = cap_y2_q;
        w_s11_d = cap_s11_q; w_s12_d = cap_s12_q; w_s22_d = cap_s22_q;
        sel_d = 1'b0;
        state_d = S_MUL;
      end
      S_MUL: begin
        p_yy11_d = fp_mul(w_y1_q[sel_q], w_y1_q[sel_q]);
        p_yy12_d = fp_mul(w_y1_q[sel_q], w_y2_q[sel_q]);
        p_yy22_d = fp_mul(w_y2_q[sel_q], w_y2_q[sel_q]);
        p_sd_d   = fp_mul(w_s11_q[sel_q], w_s22_q[sel_q]);
        p_so_d   = fp_mul(w_s12_q[sel_q], w_s12_q[sel_q]);
        state_d  = S_SUM;
      end
      S_SUM: begin
        rem_d = {16'd0, num[31:16]};
        quo_d = {num[15:0], 16'd0};
        dsr_d = det;
        deg_cur_d = (det <= 32'sd0);
        force_d = 1'b1;
        if (det <= 32'sd0)                                force_val_d = 32'h7FFF_FFFF;
        else if (num <= 32'sd0)                           force_val_d = 32'h0000_0000;
        else if ({16'd0, num} >= {1'b0, det, 15'd0})      force_val_d = 32'h7FFF_FFFF;
        else                                              force_d = 1'b0;
        dcnt_d  = '0;
        state_d = S_DIV;
      end
      default: begin
        rem_d  = ge ? 32'(r2 - {1'b0, dsr_q}) : r2[31:0];
        quo_d  = q_next;
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == 5'd31) begin
          if (!sel_q) begin
            res_cv_d = final_q;
            deg_cv_d = deg_cur_q;
            sel_d    = 1'b1;
            state_d  = S_MUL;
          end else begin
            nis_cv_d    = res_cv_q;
            nis_ca_d    = final_q;
            deg_d       = {deg_cur_q, deg_cv_q};
            nis_valid_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_y1_q <= '{default: '0}; cap_y2_q <= '{default: '0};
      cap_s11_q <= '{default: '0}; cap_s12_q <= '{default: '0}; cap_s22_q <= '{default: '0};
      w_y1_q <= '{default: '0}; w_y2_q <= '{default: '0};
      w_s11_q <= '{default: '0}; w_s12_q <= '{default: '0}; w_s22_q <= '{default: '0};
      p_yy11_q <= '0; p_yy12_q <= '0; p_yy22_q <= '0; p_sd_q <= '0; p_so_q <= '0;
      state_q <= S_IDLE; sel_q <= 1'b0; dcnt_q <= '0;
      have_cv_q <= 1'b0; have_ca_q <= 1'b0; tcnt_q <= '0;
      rem_q <= '0; quo_q <= '0; dsr_q <= '0;
      force_q <= 1'b0; force_val_q <= '0; deg_cur_q <= 1'b0;
      res_cv_q <= '0; deg_cv_q <= 1'b0;
      nis_cv_q <= '0; nis_ca_q <= '0; deg_q <= '0;
      nis_valid_q <= 1'b0; pair_drop_q <= 1'b0; overrun_q <= 1'b0;
    end else begin
      cap_y1_q <= cap_y1_d; cap_y2_q <= cap_y2_d;
      cap_s11_q <= cap_s11_d; cap_s12_q <= cap_s12_d; cap_s22_q <= cap_s22_d;
      w_y1_q <= w_y1_d; w_y2_q <= w_y2_d;
      w_s11_q <= w_s11_d; w_s12_q <= w_s12_d; w_s22_q <= w_s22_d;
      p_yy11_q <= p_yy11_d; p_yy12_q <= p_yy12_d; p_yy22_q <= p_yy22_d;
      p_sd_q <= p_sd_d; p_so_q <= p_so_d;
      state_q <= state_d; sel_q <= sel_d; dcnt_q <= dcnt_d;
      have_cv_q <= have_cv_d; have_ca_q <= have_ca_d; tcnt_q <= tcnt_d;
      rem_q <= rem_d; quo_q <= quo_d; dsr_q <= dsr_d;
      force_q <= force_d; force_val_q <= force_val_d; deg_cur_q <= deg_cur_d;
      res_cv_q <= res_cv_d; deg_cv_q <= deg_cv_d;
      nis_cv_q <= nis_cv_d; nis_ca_q <= nis_ca_d; deg_q <= deg_d;
      nis_valid_q <= nis_valid_d; pair_drop_q <= pair_drop_d; overrun_q <= overrun_d;
    end
  end

  assign nis_cv     = nis_cv_q;
  assign nis_ca     = nis_ca_q;
  assign nis_valid  = nis_valid_q;
  assign degenerate = deg_q;
  assign busy       = (state_q != S_IDLE);
  assign pair_drop  = pair_drop_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_nx_mimosa_v40_nis_calc.sv
// Scoreboard bench for nx_mimosa_v40_nis_calc: expected NIS pairs are queued
// when a pair is driven and compared when nis_valid pulses.
module tb_nx_mimosa_v40_nis_calc;

  localparam logic [31:0] ONE = 32'h0001_0000;
  localparam logic [31:0] MAXV = 32'h7FFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0][31:0] cv_y, ca_y;
  logic [31:0] cv_s11, cv_s12, cv_s22, ca_s11, ca_s12, ca_s22;
  logic cv_valid, ca_valid;
  logic [31:0] nis_cv, nis_ca;
  logic nis_valid, busy, pair_drop, overrun;
  logic [1:0] degenerate;

  nx_mimosa_v40_nis_calc #(.MEAS_DIM(2), .PAIR_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cv_y(cv_y), .cv_s11(cv_s11), .cv_s12(cv_s12), .cv_s22(cv_s22), .cv_valid(cv_valid),
    .ca_y(ca_y), .ca_s11(ca_s11), .ca_s12(ca_s12), .ca_s22(ca_s22), .ca_valid(ca_valid),
    .nis_cv(nis_cv), .nis_ca(nis_ca), .nis_valid(nis_valid), .degenerate(degenerate),
    .busy(busy), .pair_drop(pair_drop), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] cv;
    logic [31:0] ca;
    logic [1:0]  deg;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;
  int drops    = 0;
  int drop_cyc = -1;
  int overruns = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference NIS in 64-bit arithmetic with explicit saturation points.
  function automatic logic signed [31:0] m_sat(input logic signed [63:0] v);
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    return v[31:0];
  endfunction

  function automatic logic signed [31:0] m_mul(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [63:0] pa, pb;
    pa = a; pb = b;
    return m_sat((pa * pb) >>> 16);
  endfunction

  function automatic logic [31:0] ref_nis(input logic signed [31:0] y1, input logic signed [31:0] y2,
                                         input logic signed [31:0] s11, input logic signed [31:0] s12,
                                         input logic signed [31:0] s22, output logic deg);
    logic signed [63:0] n64, q;
    logic signed [31:0] num, det;
    n64 = 64'(m_mul(s22, m_mul(y1, y1)))
        - 64'(m_sat(2 * 64'(m_mul(s12, m_mul(y1, y2)))))
        + 64'(m_mul(s11, m_mul(y2, y2)));
    num = m_sat(n64);
    det = m_sat(64'(m_mul(s11, s22)) - 64'(m_mul(s12, s12)));
    deg = (det <= 0);
    if (deg) return MAXV;
    if (num <= 0) return 32'h0;
    q = (64'(num) <<< 16) / 64'(det);
    return m_sat(q);
  endfunction

  always @(negedge clk) begin
    if (pair_drop) begin drops++; drop_cyc = cyc; end
    if (overrun) overruns++;
    if (nis_valid) begin
      if (sbq.size() == 0) check("unexpected_nis_valid", 1, 0);
      else begin
        mon_e = sbq.pop_front();
        check("latency_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("nis_cv", nis_cv, mon_e.cv);
        check("nis_ca", nis_ca, mon_e.ca);
        check("degenerate", degenerate, mon_e.deg);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cv(input logic [31:0] y1, input logic [31:0] y2,
                        input logic [31:0] s11, input logic [31:0] s12, input logic [31:0] s22);
    cv_y[0] = y1; cv_y[1] = y2; cv_s11 = s11; cv_s12 = s12; cv_s22 = s22;
  endtask

  task automatic set_ca(input logic [31:0] y1, input logic [31:0] y2,
                        input logic [31:0] s11, input logic [31:0] s12, input logic [31:0] s22);
    ca_y[0] = y1; ca_y[1] = y2; ca_s11 = s11; ca_s12 = s12; ca_s22 = s22;
  endtask

  // Returns just after the sampling edge; cyc then names that edge.
  task automatic pulse(input logic v_cv, input logic v_ca);
    cv_valid = v_cv; ca_valid = v_ca;
    step();
    cv_valid = 1'b0; ca_valid = 1'b0;
  endtask

  task automatic push_exp(input int c, input logic [31:0] vcv, input logic [31:0] vca, input logic [1:0] d);
    exp_t e;
    e.cyc = c; e.cv = vcv; e.ca = vca; e.deg = d;
    sbq.push_back(e);
  endtask

  task automatic push_model(input int c);
    logic dcv, dca;
    logic [31:0] vcv, vca;
    vcv = ref_nis(cv_y[0], cv_y[1], cv_s11, cv_s12, cv_s22, dcv);
    vca = ref_nis(ca_y[0], ca_y[1], ca_s11, ca_s12, ca_s22, dca);
    push_exp(c, vcv, vca, {dca, dcv});
  endtask

  task automatic rand_data();
    set_cv(32'(int'($urandom_range(0, 1 << 20)) - (1 << 19)), 32'(int'($urandom_range(0, 1 << 20)) - (1 << 19)),
           32'(32768 + $urandom_range(0, 3 << 16)), 32'(int'($urandom_range(0, 1 << 16)) - (1 << 15)),
           32'(32768 + $urandom_range(0, 3 << 16)));
    set_ca(32'(int'($urandom_range(0, 1 << 20)) - (1 << 19)), 32'(int'($urandom_range(0, 1 << 20)) - (1 << 19)),
           32'(32768 + $urandom_range(0, 3 << 16)), 32'(int'($urandom_range(0, 1 << 16)) - (1 << 15)),
           32'(32768 + $urandom_range(0, 3 << 16)));
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_nis_cv"}, nis_cv, 0);
    check({pfx, "_nis_ca"}, nis_ca, 0);
    check({pfx, "_nis_valid"}, nis_valid, 0);
    check({pfx, "_degenerate"}, degenerate, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_pair_drop"}, pair_drop, 0);
    check({pfx, "_overrun"}, overrun, 0);
  endtask

  int c0, c1, busy_low, d0, ov0;

  initial begin
    cv_valid = 1'b0; ca_valid = 1'b0;
    set_cv('0, '0, '0, '0, '0);
    set_ca('0, '0, '0, '0, '0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    step(); step();

    // Basic simultaneous pair, busy held for the whole computation
    set_cv(ONE, 0, ONE, 0, ONE);
    set_ca(2 * ONE, 0, 2 * ONE, 0, 2 * ONE);
    pulse(1, 1);
    c0 = cyc;
    push_exp(c0 + 69, 32'h0001_0000, 32'h0002_0000, 2'b00);
    busy_low = 0;
    step();
    for (int i = 0; i < 68; i++) begin
      if (!busy) busy_low++;
      step();
    end
    check("busy_during_compute", 64'(busy_low), 0);
    check("busy_after_compute", busy, 0);
    repeat (3) step();
    check("hold_nis_cv", nis_cv, 32'h0001_0000);
    check("hold_nis_ca", nis_ca, 32'h0002_0000);

    // Staggered arrival: CV at cycle 0, CA at cycle 10
    d0 = drops;
    pulse(1, 0);
    repeat (9) step();
    pulse(0, 1);
    push_exp(cyc + 69, 32'h0001_0000, 32'h0002_0000, 2'b00);
    repeat (75) step();
    check("stagger_no_drop", 64'(drops), 64'(d0));

    // Lone CV times out after 64 cycles
    pulse(1, 0);
    c0 = cyc;
    repeat (70) step();
    check("timeout_drop_count", 64'(drops), 64'(d0 + 1));
    check("timeout_drop_cycle", 64'(drop_cyc), 64'(c0 + 64));
    set_cv(ONE, ONE, ONE, 0, ONE);
    pulse(1, 1);
    push_exp(cyc + 69, 32'h0002_0000, 32'h0002_0000, 2'b00);
    repeat (72) step();

    // Degenerate CA covariance (det = 0)
    set_cv(ONE, 0, ONE, 0, ONE);
    set_ca(2 * ONE, 0, ONE, ONE, ONE);
    pulse(1, 1);
    push_exp(cyc + 69, 32'h0001_0000, MAXV, 2'b10);
    repeat (75) step();
    check("hold_degenerate", degenerate, 2'b10);

    // Overrun: CV overwritten before CA arrives
    ov0 = overruns;
    set_cv(ONE, 0, ONE, 0, ONE);
    pulse(1, 0);
    set_cv(3 * ONE, 0, ONE, 0, ONE);
    pulse(1, 0);
    step();
    check("overrun_count", 64'(overruns), 64'(ov0 + 1));
    set_ca(2 * ONE, 0, 2 * ONE, 0, 2 * ONE);
    pulse(0, 1);
    push_exp(cyc + 69, 32'h0009_0000, 32'h0002_0000, 2'b00);
    repeat (72) step();

    // Saturation of y1^2
    set_cv(32'h012C_0000, 0, ONE, 0, ONE);
    pulse(1, 1);
    push_exp(cyc + 69, MAXV, 32'h0002_0000, 2'b00);
    repeat (72) step();

    // Random pairs against the reference model
    for (int k = 0; k < 4; k++) begin
      rand_data();
      pulse(1, 1);
      push_model(cyc + 69);
      repeat (72) step();
    end

    // Pair arriving while busy waits for the first idle edge
    rand_data();
    pulse(1, 1);
    c1 = cyc;
    push_model(c1 + 69);
    rand_data();
    repeat (5) step();
    pulse(1, 1);
    push_model(c1 + 138);
    repeat (145) step();

    // Reset during the CV divide aborts the computation
    set_cv(ONE, 0, ONE, 0, ONE);
    set_ca(2 * ONE, 0, 2 * ONE, 0, 2 * ONE);
    pulse(1, 1);
    repeat (20) step();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    sbq.delete();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (75) step();
    pulse(1, 1);
    push_exp(cyc + 69, 32'h0001_0000, 32'h0002_0000, 2'b00);
    repeat (72) step();

    check("scoreboard_drained", 64'(sbq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
